div_repsub: RTL

DIV_REPSUB -- requirements
Module: div_repsub

---
 rtl/div_pkg.sv | 15 +
 rtl/div_datapath.sv | 65 ++++++
 rtl/div_repsub.sv | 113 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: default operand
// width and the controller state encoding.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_datapath.sv
// Datapath of the repeated-subtraction divider: working dividend A, divisor B,
// quotient Q and the divide-by-zero flag, with the subtractor, the unsigned
// A>=B comparator and the B==0 detector whose flags steer the controller.
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             sub_en,
  input  logic             set_dz,
  output logic [WIDTH-1:0] a_val,
  output logic [WIDTH-1:0] q_val,
  output logic             div_zero,
  output logic             a_ge_b,
  output logic             b_eqz
);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] q_r;
  logic             dz_r;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] q_inc_s;

  assign diff_s  = a_r - b_r;
  assign q_inc_s = q_r + WIDTH'(1);

  // Operand, quotient and divide-by-zero registers; one control acts per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r  <= {WIDTH{1'b0}};
      b_r  <= {WIDTH{1'b0}};
      q_r  <= {WIDTH{1'b0}};
      dz_r <= 1'b0;
    end else if (load_a) begin
      a_r <= data_in;
    end else if (load_b) begin
      b_r  <= data_in;
      q_r  <= {WIDTH{1'b0}};
      dz_r <= 1'b0;
    end else if (sub_en) begin
      a_r <= diff_s;
      q_r <= q_inc_s;
    end else if (set_dz) begin
      dz_r <= 1'b1;
    end else begin
      a_r  <= a_r;
      b_r  <= b_r;
      q_r  <= q_r;
      dz_r <= dz_r;
    end
  end

  assign a_ge_b   = (a_r >= b_r);
  assign b_eqz    = (b_r == {WIDTH{1'b0}});
  assign a_val    = a_r;
  assign q_val    = q_r;
  assign div_zero = dz_r;

endmodule

// File: rtl/div_repsub.sv
// Repeated-subtraction unsigned divider. Dividend and divisor arrive on one
// shared bus on consecutive cycles after start; the controller subtracts B
// from A once per cycle until A<B, or stops at once when B is zero.
module div_repsub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_zero
);

  div_state_e state_r;
  div_state_e state_next_s;
  logic       load_a_s;
  logic       load_b_s;
  logic       sub_en_s;
  logic       set_dz_s;
  logic       a_ge_b_s;
  logic       b_eqz_s;
  logic       done_r;
  logic       busy_r;

  div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .load_a  (load_a_s),
    .load_b  (load_b_s),
    .sub_en  (sub_en_s),
    .set_dz  (set_dz_s),
    .a_val   (remainder),
    .q_val   (quotient),
    .div_zero(div_zero),
    .a_ge_b  (a_ge_b_s),
    .b_eqz   (b_eqz_s)
  );

  // State register plus done/busy flops, which are loaded from the next state
  // so they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= (state_next_s == DONE);
      busy_r  <= (state_next_s == LDA) || (state_next_s == LDB) ||
                 (state_next_s == RUN);
    end
  end

  // Next-state and datapath control decode; decisions use only a_ge_b/b_eqz.
  always_comb begin
    state_next_s = state_r;
    load_a_s     = 1'b0;
    load_b_s     = 1'b0;
    sub_en_s     = 1'b0;
    set_dz_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = LDA;
        end else begin
          state_next_s = IDLE;
        end
      end
      LDA: begin
        load_a_s     = 1'b1;
        state_next_s = LDB;
      end
      LDB: begin
        load_b_s     = 1'b1;
        state_next_s = RUN;
      end
      RUN: begin
        if (b_eqz_s) begin
          set_dz_s     = 1'b1;
          state_next_s = DONE;
        end else if (a_ge_b_s) begin
          sub_en_s     = 1'b1;
          state_next_s = RUN;
        end else begin
          state_next_s = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign done = done_r;
  assign busy = busy_r;

endmodule
